div_unit: RTL

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions; the inverse-operation counterpart to the single-cycle multiplier in the execute-stage ALU. It sits beside the ALU in EX: the hazard unit stalls the pipeline while `busy` is high, and `result` is written back on the `done` pulse. It uses one restoring step per cycle, with special-case bypass and a final sign fix-up.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 22 ++
 rtl/div_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  // funct3[1:0] encoding of the four divide/remainder instructions.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  // Controller states: idle, iterating, sign fix-up, result presented.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  // Magnitude of a two's-complement word; INT_MIN maps to 2^31 as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference only if it did not go negative.
module div_step (
  input  logic [32:0] rem,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [33:0] diff;

  // The extra top bit acts as the borrow/sign of the trial subtraction.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[33];
    rem_next = q_bit ? diff[32:0] : shifted[32:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU. Special cases (divide by
// zero, signed overflow) finish in one cycle; everything else runs 32
// restoring steps on magnitudes followed by a sign fix-up cycle.
//
// Handshake: a request is taken on a rising edge where start=1, kill=0 and
// the unit is not busy (IDLE or DONE state). done is a one-cycle pulse with
// result valid in that cycle; result then holds until the next done. There
// is no backpressure on done. kill drops both a pending request and any
// operation in flight without producing done.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output div_state_e      dbg_state
);

  div_state_e  state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] dvd_q, dvs_q, quot_q, result_q;
  logic [32:0] rem_q;
  logic        rem_sel_q, neg_q_q, neg_r_q;

  logic        accept, is_signed, div_zero, overflow, special;
  logic [31:0] special_res, fix_val;
  logic [32:0] step_rem;
  logic        step_q_bit;

  div_step u_step (
    .rem          (rem_q),
    .dividend_bit (dvd_q[count_q]),
    .divisor      (dvs_q),
    .rem_next     (step_rem),
    .q_bit        (step_q_bit)
  );

  // Request acceptance, special-case classification and final sign fix-up.
  always_comb begin
    accept      = start && !kill && (state_q == IDLE || state_q == DONE);
    is_signed   = ~op[0];
    div_zero    = (b == '0);
    overflow    = is_signed && (a == INT_MIN) && (b == ALL_ONES);
    special     = div_zero || overflow;
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? a : ALL_ONES;
    else
      special_res = op[1] ? 32'd0 : INT_MIN;
    if (rem_sel_q)
      fix_val = neg_r_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    else
      fix_val = neg_q_q ? (~quot_q + 32'd1) : quot_q;
  end

  // Next-state logic; kill overrides everything, including a new start.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start)
            state_d = special ? DONE : CALC;
          else
            state_d = IDLE;
        end
        CALC:    if (count_q == 5'd0) state_d = FIX;
        FIX:     state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand capture, iteration registers and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
    end else if (!kill) begin
      if (accept) begin
        rem_sel_q <= op[1];
        if (special) begin
          result_q <= special_res;
        end else begin
          dvd_q   <= is_signed ? abs32(a) : a;
          dvs_q   <= is_signed ? abs32(b) : b;
          neg_q_q <= is_signed && (a[31] ^ b[31]);
          neg_r_q <= is_signed && a[31];
          rem_q   <= '0;
          quot_q  <= '0;
          count_q <= 5'(DIV_STEPS - 1);
        end
      end else if (state_q == CALC) begin
        rem_q   <= step_rem;
        quot_q  <= {quot_q[30:0], step_q_bit};
        count_q <= count_q - 5'd1;
      end else if (state_q == FIX) begin
        result_q <= fix_val;
      end
    end
  end

  // All outputs decode registered state only.
  always_comb begin
    busy      = (state_q == CALC) || (state_q == FIX);
    done      = (state_q == DONE);
    result    = result_q;
    dbg_state = state_q;
  end

endmodule
